// File: rtl/uart_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_rx_fifo                                                 |
// | Description : Console UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN)   |
// |               with a byte FIFO, read on I/O ports 0xE8 (data) / 0xE9 (st). |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module uart_rx_fifo #(
    parameter int CLK_HZ     = 20_000_000,
    parameter int BAUD       = 115200,
    parameter int OSDIV      = (CLK_HZ + BAUD * 8) / (BAUD * 16),
    parameter int DEPTH_LOG2 = 4
) (
    input  logic       CLK20,
    input  logic       CRST,
    input  logic       UART_RX,
    input  logic       IORD_N,
    input  logic [7:0] ADDR,
    input  logic       TX_BSY,
    output logic [7:0] DOUT,
    output logic       RX_READY
);

    localparam int                    c_DIVW     = (OSDIV > 1) ? $clog2(OSDIV) : 1;
    localparam logic [c_DIVW-1:0]     c_DIV_MAX  = c_DIVW'(OSDIV - 1);
    localparam logic [c_DIVW-1:0]     c_DIV_ONE  = c_DIVW'(1);
    localparam int                    c_DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   c_FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   c_CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [7:0]            c_ADDR_DAT = 8'hE8;
    localparam logic [7:0]            c_ADDR_STA = 8'hE9;

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_START  = 3'd1;
    localparam logic [2:0] c_S_DATA   = 3'd2;
    localparam logic [2:0] c_S_STOP   = 3'd3;
    localparam logic [2:0] c_S_WAITHI = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] c_S_PARITY = 3'd5;
`endif

    logic                  r_rx_s1, r_rx_s2, r_rx_prev;
    logic                  r_rd_s1, r_rd_s2, r_rd_prev;
    logic [c_DIVW-1:0]     r_div;
    logic [2:0]            r_state;
    logic [3:0]            r_tcnt;
    logic [2:0]            r_bitn;
    logic [7:0]            r_sh;
    logic [7:0]            r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0] r_wptr, r_rptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_ready;
    logic                  r_ovr, r_fe;
    logic [7:0]            r_dout;

    logic                  w_tick, w_rx_fall, w_rd_evt;
    logic                  w_stop_smp, w_push, w_fe_set;
    logic                  w_rd_data, w_rd_stat;
    logic                  w_empty, w_full, w_pop_ok, w_push_ok, w_ovr_set;
    logic [DEPTH_LOG2:0]   w_count_next;
    logic                  w_pe_bit;
    logic [7:0]            w_status;

    assign w_tick     = (r_div == c_DIV_MAX);
    assign w_rx_fall  = r_rx_prev & ~r_rx_s2;
    assign w_rd_evt   = r_rd_prev & ~r_rd_s2;

    assign w_stop_smp = (r_state == c_S_STOP) && w_tick && (r_tcnt == 4'd15);
    assign w_push     = w_stop_smp & r_rx_s2;
    assign w_fe_set   = w_stop_smp & ~r_rx_s2;

    assign w_rd_data  = w_rd_evt && (ADDR == c_ADDR_DAT);
    assign w_rd_stat  = w_rd_evt && (ADDR == c_ADDR_STA);

    // Pop is resolved first, so a full FIFO still accepts a byte on a pop cycle.
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_FULL_CNT);
    assign w_pop_ok   = w_rd_data & ~w_empty;
    assign w_push_ok  = w_push & (~w_full | w_pop_ok);
    assign w_ovr_set  = w_push & w_full & ~w_pop_ok;

    always_comb begin
        w_count_next = r_count;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_next = r_count + c_CNT_ONE;
            2'b01:   w_count_next = r_count - c_CNT_ONE;
            default: w_count_next = r_count;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    logic r_pe;
    logic w_pe_set;
    assign w_pe_set = (r_state == c_S_PARITY) && w_tick && (r_tcnt == 4'd15)
                      && (r_rx_s2 != ^r_sh);
    assign w_pe_bit = r_pe;

    always_ff @(posedge CLK20 or negedge CRST) begin
        if (!CRST) begin
            r_pe <= 1'b0;
        end else begin
            r_pe <= (r_pe & ~w_rd_stat) | w_pe_set;
        end
    end
`else
    assign w_pe_bit = 1'b0;
`endif

    assign w_status = {TX_BSY, 3'b000, w_pe_bit, w_full, r_fe, r_ovr, r_ready};

    always_ff @(posedge CLK20 or negedge CRST) begin
        if (!CRST) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
            r_rd_s1   <= 1'b1;
            r_rd_s2   <= 1'b1;
            r_rd_prev <= 1'b1;
            r_div     <= '0;
        end else begin
            r_rx_s1   <= UART_RX;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
            r_rd_s1   <= IORD_N;
            r_rd_s2   <= r_rd_s1;
            r_rd_prev <= r_rd_s2;
            r_div     <= w_tick ? '0 : (r_div + c_DIV_ONE);
        end
    end

    // Start bit is rechecked at tick 8; later bits are sampled every 16 ticks.
    always_ff @(posedge CLK20 or negedge CRST) begin
        if (!CRST) begin
            r_state <= c_S_IDLE;
            r_tcnt  <= 4'd0;
            r_bitn  <= 3'd0;
            r_sh    <= 8'h00;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_rx_fall) begin
                        r_state <= c_S_START;
                        r_tcnt  <= 4'd0;
                    end
                end
                c_S_START: begin
                    if (w_tick) begin
                        if (r_tcnt == 4'd7) begin
                            r_tcnt  <= 4'd0;
                            r_bitn  <= 3'd0;
                            r_state <= r_rx_s2 ? c_S_IDLE : c_S_DATA;
                        end else begin
                            r_tcnt <= r_tcnt + 4'd1;
                        end
                    end
                end
                c_S_DATA: begin
                    if (w_tick) begin
                        if (r_tcnt == 4'd15) begin
                            r_tcnt <= 4'd0;
                            r_sh   <= {r_rx_s2, r_sh[7:1]};
                            r_bitn <= r_bitn + 3'd1;
                            if (r_bitn == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                r_state <= c_S_PARITY;
`else
                                r_state <= c_S_STOP;
`endif
                            end
                        end else begin
                            r_tcnt <= r_tcnt + 4'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                c_S_PARITY: begin
                    if (w_tick) begin
                        if (r_tcnt == 4'd15) begin
                            r_tcnt  <= 4'd0;
                            r_state <= c_S_STOP;
                        end else begin
                            r_tcnt <= r_tcnt + 4'd1;
                        end
                    end
                end
`endif
                c_S_STOP: begin
                    if (w_tick) begin
                        if (r_tcnt == 4'd15) begin
                            r_tcnt  <= 4'd0;
                            r_state <= r_rx_s2 ? c_S_IDLE : c_S_WAITHI;
                        end else begin
                            r_tcnt <= r_tcnt + 4'd1;
                        end
                    end
                end
                c_S_WAITHI: begin
                    if (r_rx_s2) begin
                        r_state <= c_S_IDLE;
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK20) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= r_sh;
        end
    end

    always_ff @(posedge CLK20 or negedge CRST) begin
        if (!CRST) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ready <= 1'b0;
            r_ovr   <= 1'b0;
            r_fe    <= 1'b0;
            r_dout  <= 8'hFF;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            r_count <= w_count_next;
            r_ready <= (w_count_next != '0);
            // A flag raised in the same cycle as a status read survives the clear.
            r_ovr   <= (r_ovr & ~w_rd_stat) | w_ovr_set;
            r_fe    <= (r_fe & ~w_rd_stat) | w_fe_set;
            if (w_rd_data) begin
                r_dout <= w_empty ? 8'h00 : r_mem[r_rptr];
            end else if (w_rd_stat) begin
                r_dout <= w_status;
            end
        end
    end

    assign DOUT     = r_dout;
    assign RX_READY = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_rx_fifo                                              |
// | Description : Scoreboard bench for uart_rx_fifo against a queue model.     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_uart_rx_fifo;

    localparam int         CLK_HZ  = 20_000_000;
    localparam int         BAUD    = 115200;
    localparam int         OSDIV   = (CLK_HZ + BAUD * 8) / (BAUD * 16);
    localparam int         BIT_CYC = 16 * OSDIV;
    localparam logic [7:0] A_DATA  = 8'hE8;
    localparam logic [7:0] A_STAT  = 8'hE9;

    logic       CLK20   = 1'b0;
    logic       CRST    = 1'b0;
    logic       UART_RX = 1'b1;
    logic       IORD_N  = 1'b1;
    logic [7:0] ADDR    = 8'h00;
    logic       TX_BSY  = 1'b0;
    logic [7:0] DOUT;
    logic       RX_READY;

    uart_rx_fifo #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .DEPTH_LOG2 (4)
    ) dut (
        .CLK20    (CLK20),
        .CRST     (CRST),
        .UART_RX  (UART_RX),
        .IORD_N   (IORD_N),
        .ADDR     (ADDR),
        .TX_BSY   (TX_BSY),
        .DOUT     (DOUT),
        .RX_READY (RX_READY)
    );

    always #25 CLK20 = ~CLK20;

    int cyc = 0;
    always @(posedge CLK20) cyc <= cyc + 1;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] model_q[$];
    bit         m_ovr = 1'b0;
    bit         m_fe  = 1'b0;
    logic [7:0] m_dout = 8'hFF;
    logic [7:0] exp_dout_q[$];
    bit         exp_rdy_q[$];
    string      exp_name_q[$];
    int         s_last = 0;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    // Drives one frame starting at the current negedge; the model takes the byte once it is complete.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        UART_RX = 1'b0;
        s_last  = cyc;
        repeat (BIT_CYC) @(negedge CLK20);
        for (int i = 0; i < 8; i++) begin
            UART_RX = b[i];
            repeat (BIT_CYC) @(negedge CLK20);
        end
        if (stop_ok) begin
            UART_RX = 1'b1;
            repeat (BIT_CYC) @(negedge CLK20);
            if (model_q.size() == 16) m_ovr = 1'b1;
            else model_q.push_back(b);
        end else begin
            UART_RX = 1'b0;
            repeat (2 * BIT_CYC) @(negedge CLK20);
            m_fe    = 1'b1;
            UART_RX = 1'b1;
            repeat (BIT_CYC) @(negedge CLK20);
        end
    endtask

    task automatic do_read(input string name, input logic [7:0] a);
        logic [7:0] e;
        e = m_dout;
        if (a == A_DATA) begin
            if (model_q.size() != 0) e = model_q.pop_front();
            else e = 8'h00;
        end else if (a == A_STAT) begin
            e = {TX_BSY, 3'b000, 1'b0, model_q.size() == 16, m_fe, m_ovr, model_q.size() != 0};
            m_ovr = 1'b0;
            m_fe  = 1'b0;
        end
        m_dout = e;
        exp_dout_q.push_back(e);
        exp_rdy_q.push_back(model_q.size() != 0);
        exp_name_q.push_back(name);
        ADDR   = a;
        IORD_N = 1'b0;
        repeat (8) @(negedge CLK20);
        IORD_N = 1'b1;
        repeat (6) @(negedge CLK20);
    endtask

    initial begin
        string nm;
        forever begin
            @(negedge IORD_N);
            repeat (5) @(negedge CLK20);
            if (exp_dout_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_read: got DOUT 0x%02h, expected no read event", DOUT);
            end else begin
                nm = exp_name_q.pop_front();
                check8({nm, "_dout"}, DOUT, exp_dout_q.pop_front());
                check8({nm, "_rdy"}, {7'd0, RX_READY}, {7'd0, exp_rdy_q.pop_front()});
            end
        end
    end

    initial begin
        repeat (120000) @(posedge CLK20);
        $display("FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "timeout");
    end

    initial begin
        int         s_cal, p_cal, lat, target;
        bit         got;
        logic [7:0] b_new;
        int         nframes;

        repeat (5) @(negedge CLK20);
        CRST = 1'b1;
        repeat (5) @(negedge CLK20);
        check8("reset_dout", DOUT, 8'hFF);
        check8("reset_rdy", {7'd0, RX_READY}, 8'h00);

        // Single byte; the RX_READY rise also yields the start-to-push latency.
        got   = 1'b0;
        p_cal = 0;
        fork
            send_frame(8'h55, 1'b1);
            begin
                for (int i = 0; i < 12 * BIT_CYC && !got; i++) begin
                    @(negedge CLK20);
                    if (RX_READY) begin
                        got   = 1'b1;
                        p_cal = cyc;
                    end
                end
            end
        join
        s_cal = s_last;
        lat   = p_cal - s_cal;
        check8("rdy_rise_seen", {7'd0, got}, 8'h01);
        n_checks++;
        if (lat < 1665 || lat > 1675) begin
            n_errors++;
            $display("FAIL rx_latency: got %0d cycles, expected 1665..1675", lat);
        end
        do_read("t1_stat", A_STAT);
        do_read("t1_data", A_DATA);

        // Overflow: 17 bytes into a 16-deep FIFO.
        for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1);
        do_read("t2_stat_ovr", A_STAT);

        // Push into a full FIFO on exactly the pop edge, aligned to the divider phase.
        while (((cyc - s_cal) % OSDIV) != 0) @(negedge CLK20);
        b_new  = 8'($urandom);
        target = cyc + lat - 3;
        fork
            send_frame(b_new, 1'b1);
            begin
                while (cyc < target) @(negedge CLK20);
                do_read("t5_pop", A_DATA);
            end
        join
        do_read("t5_stat_full", A_STAT);
        for (int i = 0; i < 16; i++) do_read("t5_drain", A_DATA);
        do_read("t2_stat_clear", A_STAT);

        // Framing error, then a clean frame to show the receiver recovers.
        send_frame(8'hA5, 1'b0);
        check8("fe_no_push", {7'd0, RX_READY}, 8'h00);
        do_read("t3_stat_fe", A_STAT);
        send_frame(8'h3C, 1'b1);
        do_read("t3_data", A_DATA);

        // 200 ns glitch.
        UART_RX = 1'b0;
        repeat (4) @(negedge CLK20);
        UART_RX = 1'b1;
        repeat (3 * BIT_CYC) @(negedge CLK20);
        check8("glitch_rdy", {7'd0, RX_READY}, 8'h00);
        do_read("t4_stat", A_STAT);

        // Reset in the middle of a data byte.
        send_frame(8'($urandom), 1'b1);
        check8("preload_rdy", {7'd0, RX_READY}, 8'h01);
        TX_BSY  = 1'b1;
        UART_RX = 1'b0;
        repeat (BIT_CYC) @(negedge CLK20);
        UART_RX = 1'b1;
        repeat (3 * BIT_CYC) @(negedge CLK20);
        CRST = 1'b0;
        repeat (3) @(negedge CLK20);
        check8("midreset_dout", DOUT, 8'hFF);
        check8("midreset_rdy", {7'd0, RX_READY}, 8'h00);
        CRST = 1'b1;
        model_q.delete();
        m_ovr  = 1'b0;
        m_fe   = 1'b0;
        m_dout = 8'hFF;
        repeat (7 * BIT_CYC) @(negedge CLK20);
        do_read("t6_stat", A_STAT);

        // Random mix of frames and reads at all addresses.
        nframes = 0;
        for (int k = 0; k < 28; k++) begin
            int         op;
            logic [7:0] a;
            op     = $urandom_range(0, 3);
            TX_BSY = 1'($urandom_range(0, 1));
            if (op == 0 && nframes < 8) begin
                send_frame(8'($urandom), 1'b1);
                nframes++;
            end else if (op == 1) begin
                do_read("rnd_data", A_DATA);
            end else if (op == 2) begin
                do_read("rnd_stat", A_STAT);
            end else begin
                a = 8'($urandom_range(0, 255));
                if (a == A_DATA || a == A_STAT) a = 8'h00;
                do_read("rnd_other", a);
            end
        end

        repeat (20) @(negedge CLK20);
        n_checks++;
        if (exp_dout_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_dout_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
